// File: rtl/adder_ring_period_counter.sv
// adder_ring_period_counter
//    Measurement stage for the instrumented Sklansky adder. Enables the adder's
//    ring-oscillator loop, synchronises its tap into wb_clk_i and counts rising
//    edges over a programmable gate window. The count is proportional to the
//    ring frequency. Ring frequency must stay below f_clk/2; faster rings alias.
module adder_ring_period_counter #(
   parameter int WIN_W         = 16,
   parameter int CNT_W         = 24,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start,
   input  logic [WIN_W-1:0] window_cycles,
   input  logic             ring_in,
   output logic             ring_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   // Timer must hold both the settle length and the largest gate window.
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_COUNT,
      ST_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [WIN_W-1:0] win_q;
   logic             s1, s2, s3;
   logic             ring_edge;
   logic             load_win;
   logic             clr_cnt;
   logic             cnt_en;
   logic             run_nxt;

   // Three-flop synchroniser for the asynchronous ring tap; runs in every state.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
         s1 <= ring_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // s2/s3 are both past the metastability flop; only rising edges count.
   assign ring_edge = s2 & ~s3;

   // State and gate timer register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   // Next-state logic: settle in ARM, gate in COUNT, hold result in DONE.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      state_nxt = state;
      timer_nxt = timer;
      load_win  = 1'b0;
      clr_cnt   = 1'b0;
      cnt_en    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt = ST_ARM;
               timer_nxt = TMR_W'(SETTLE_CYCLES - 1);
               load_win  = 1'b1;
               clr_cnt   = 1'b1;
            end
         end
         ST_ARM: begin
            if (timer == '0) begin
               if (win_q == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_COUNT;
                  timer_nxt = TMR_W'(win_q) - TMR_W'(1);
               end
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         ST_COUNT: begin
            cnt_en = 1'b1;
            if (timer == '0) begin
               state_nxt = ST_DONE;
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign run_nxt = (state_nxt == ST_ARM) || (state_nxt == ST_COUNT);

   // Status outputs are flops loaded from the next state, so they change
   // on the same edge as the state and never depend combinationally on inputs.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ring_en <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         ring_en <= run_nxt;
         busy    <= run_nxt;
         done    <= (state_nxt == ST_DONE);
      end
   end

   // Gate length is captured only when a start is accepted; stable for the run.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         win_q <= '0;
      end else if (load_win) begin
         win_q <= window_cycles;
      end
   end

   // Saturating edge counter with sticky overflow, cleared when a run starts.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr_cnt) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (cnt_en && ring_edge) begin
         if (count == CNT_MAX) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_adder_ring_period_counter.sv
// Testbench for adder_ring_period_counter: table of ring/window vectors with a
// scoreboard of expected results, plus hand sequences for handshake and abort.
module tb_adder_ring_period_counter;

   localparam int SETTLE = 8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        start;
   logic [15:0] window_cycles;
   logic        ring_in;

   logic        ring_en, busy, done, overflow;
   logic [23:0] count;
   logic        s_ring_en, s_busy, s_done, s_overflow;
   logic [3:0]  s_count;

   int checks = 0;
   int errors = 0;

   adder_ring_period_counter #(.WIN_W(16), .CNT_W(24), .SETTLE_CYCLES(SETTLE)) dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .start         (start),
      .window_cycles (window_cycles),
      .ring_in       (ring_in),
      .ring_en       (ring_en),
      .busy          (busy),
      .done          (done),
      .count         (count),
      .overflow      (overflow)
   );

   // Narrow-counter instance shares all inputs; used for saturation.
   adder_ring_period_counter #(.WIN_W(16), .CNT_W(4), .SETTLE_CYCLES(SETTLE)) dut_sat (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_i      (wb_rst_i),
      .start         (start),
      .window_cycles (window_cycles),
      .ring_in       (ring_in),
      .ring_en       (s_ring_en),
      .busy          (s_busy),
      .done          (s_done),
      .count         (s_count),
      .overflow      (s_overflow)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Ring source: toggles every ring_half clocks at t = 3 mod 10 ns, well away
   // from the rising clock edges at t = 5 mod 10 ns; ring_half = 0 holds ring_level.
   int      ring_half  = 1;
   logic    ring_level = 1'b0;
   longint  tick       = 0;

   initial begin
      ring_in = 1'b0;
      forever begin
         #1;
         tick++;
         if (ring_half == 0) ring_in = ring_level;
         else if ((tick % longint'(ring_half * 10)) == 3) ring_in = ~ring_in;
      end
   end

   typedef struct {
      int   half;
      logic level;
      int   win;
      int   exp_cnt;
      logic exp_ovf;
      int   exp_scnt;
      logic exp_sovf;
   } vec_t;

   typedef struct {
      int   busy_len;
      int   cnt;
      logic ovf;
      int   scnt;
      logic sovf;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Called at a falling edge; returns at the first falling edge of the run.
   task automatic do_start(input int win);
      start         = 1'b1;
      window_cycles = 16'(win);
      @(negedge wb_clk_i);
      start         = 1'b0;
      window_cycles = 16'($urandom);
   endtask

   // Counts busy cycles until done; optionally pulses start at cycle inject_at.
   task automatic wait_done(input string tag, input int inject_at);
      int   n   = 0;
      bit   got = 1'b0;
      exp_t e;
      for (int c = 0; c < 3000; c++) begin
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (busy === 1'b1) n++;
         if (c == inject_at) begin
            start         = 1'b1;
            window_cycles = 16'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge wb_clk_i);
      end
      start = 1'b0;
      check({tag, " done_seen"}, 64'(got), 64'd1);
      if (sb.size() == 0) begin
         check({tag, " scoreboard_nonempty"}, 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " busy_len"},  64'(n),          64'(e.busy_len));
         check({tag, " count"},     64'(count),      64'(e.cnt));
         check({tag, " overflow"},  64'(overflow),   64'(e.ovf));
         check({tag, " sat_count"}, 64'(s_count),    64'(e.scnt));
         check({tag, " sat_ovf"},   64'(s_overflow), 64'(e.sovf));
         check({tag, " ring_en"},   64'(ring_en),    64'd0);
         check({tag, " busy_off"},  64'(busy),       64'd0);
         check({tag, " sat_done"},  64'(s_done),     64'd1);
      end
   endtask

   initial begin
      // {half, level, window, count, ovf, sat count, sat ovf}
      vecs[0] = '{5, 1'b0, 100, 10, 1'b0, 10, 1'b0};
      vecs[1] = '{0, 1'b1,  50,  0, 1'b0,  0, 1'b0};
      vecs[2] = '{0, 1'b0,  20,  0, 1'b0,  0, 1'b0};
      vecs[3] = '{2, 1'b0,  40, 10, 1'b0, 10, 1'b0};
      vecs[4] = '{1, 1'b0,  64, 32, 1'b0, 15, 1'b1};
      vecs[5] = '{1, 1'b0,  30, 15, 1'b0, 15, 1'b0};
      vecs[6] = '{3, 1'b0,  60, 10, 1'b0, 10, 1'b0};

      start         = 1'b0;
      window_cycles = '0;
      wb_rst_i      = 1'b1;

      // Reset held two cycles while ring toggles and start is requested.
      start = 1'b1;
      repeat (2) @(negedge wb_clk_i);
      check("rst ring_en",  64'(ring_en),  64'd0);
      check("rst busy",     64'(busy),     64'd0);
      check("rst done",     64'(done),     64'd0);
      check("rst count",    64'(count),    64'd0);
      check("rst overflow", 64'(overflow), 64'd0);
      check("rst sat_busy", 64'(s_busy),   64'd0);
      start    = 1'b0;
      wb_rst_i = 1'b0;
      repeat (2) @(negedge wb_clk_i);
      check("idle busy", 64'(busy), 64'd0);
      check("idle done", 64'(done), 64'd0);

      // Table-driven measurements.
      for (int i = 0; i < 7; i++) begin
         ring_half  = vecs[i].half;
         ring_level = vecs[i].level;
         repeat (4) @(negedge wb_clk_i);
         sb.push_back('{SETTLE + vecs[i].win, vecs[i].exp_cnt, vecs[i].exp_ovf,
                        vecs[i].exp_scnt, vecs[i].exp_sovf});
         do_start(vecs[i].win);
         wait_done($sformatf("vec%0d", i), -1);
      end

      // Start pulsed 20 cycles into COUNT must be ignored.
      ring_half = 5;
      repeat (4) @(negedge wb_clk_i);
      sb.push_back('{SETTLE + 100, 10, 1'b0, 10, 1'b0});
      do_start(100);
      wait_done("midstart", SETTLE + 20);
      repeat (3) @(negedge wb_clk_i);
      check("done_held",  64'(done),  64'd1);
      check("count_held", 64'(count), 64'd10);

      // Start from DONE with a zero window: ARM only, then DONE.
      sb.push_back('{SETTLE, 0, 1'b0, 0, 1'b0});
      do_start(0);
      wait_done("win0", -1);

      // Abort: reset pulsed 20 cycles into COUNT.
      repeat (2) @(negedge wb_clk_i);
      do_start(100);
      repeat (SETTLE + 20) @(negedge wb_clk_i);
      check("abort pre busy",  64'(busy),  64'd1);
      check("abort pre count", 64'(count), 64'd2);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      check("abort ring_en",  64'(ring_en),  64'd0);
      check("abort busy",     64'(busy),     64'd0);
      check("abort count",    64'(count),    64'd0);
      check("abort done",     64'(done),     64'd0);
      check("abort overflow", 64'(overflow), 64'd0);
      repeat (3) @(negedge wb_clk_i);
      check("abort stays idle", 64'(busy | done), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
